fifo_sync_128: RTL and testbench

Synchronous single-clock FIFO with 128-bit data. It is the storage end of the FIFO write/read interface. It accepts `i_wren`/`i_wrdata` and `i_rden` from the driver side. It returns `o_rddata` and the status flags `o_full`, `o_empty`, `o_alm_full` and `o_alm_empty` that the monitor side samples on the posedge of `clk`. It is the DUT behind the UVM FIFO environment.

---
 rtl/fifo_sync_128.sv | 106 ++++++++++
 tb/tb_fifo_sync_128.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_sync_128.sv
// Synchronous single-clock FIFO with registered read data and registered status flags.
// Optional macro FIFO_SYNC_ERR_EN adds o_overflow / o_underflow refused-request pulses.
module fifo_sync_128 #(
  parameter int DATA_W        = 128,
  parameter int DEPTH         = 16,
  parameter int ALM_FULL_LVL  = 12,
  parameter int ALM_EMPTY_LVL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty
`ifdef FIFO_SYNC_ERR_EN
  ,
  output logic              o_overflow,
  output logic              o_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(ALM_FULL_LVL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(ALM_EMPTY_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp_reg, rp_reg;
  logic [AW:0]       count_reg, count_next;
  logic [DATA_W-1:0] rddata_reg;
  logic              full_reg, empty_reg, alm_full_reg, alm_empty_reg;
  logic              wr_ok, rd_ok;

  // Gating on the registered flags resolves the full/empty simultaneous cases.
  assign wr_ok = i_wren && !full_reg;
  assign rd_ok = i_rden && !empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp_reg] <= i_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      rddata_reg    <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      alm_full_reg  <= 1'b0;
      alm_empty_reg <= 1'b1;
    end else begin
      if (wr_ok) begin
        wp_reg <= wp_reg + 1'b1;
      end
      if (rd_ok) begin
        rp_reg     <= rp_reg + 1'b1;
        rddata_reg <= mem[rp_reg];
      end
      count_reg     <= count_next;
      full_reg      <= (count_next == FULL_CNT);
      empty_reg     <= (count_next == '0);
      alm_full_reg  <= (count_next >= AF_CNT);
      alm_empty_reg <= (count_next <= AE_CNT);
    end
  end

  assign o_rddata    = rddata_reg;
  assign o_full      = full_reg;
  assign o_empty     = empty_reg;
  assign o_alm_full  = alm_full_reg;
  assign o_alm_empty = alm_empty_reg;

`ifdef FIFO_SYNC_ERR_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= i_wren && full_reg;
      underflow_reg <= i_rden && empty_reg;
    end
  end

  assign o_overflow  = overflow_reg;
  assign o_underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_sync_128.sv
// Table-driven directed bench for fifo_sync_128 (DEPTH 16, levels 12/4).
module tb_fifo_sync_128;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wren = 1'b0;
  logic         rden = 1'b0;
  logic [127:0] wrdata = '0;
  logic [127:0] rddata;
  logic         full, empty, alm_full, alm_empty;
`ifdef FIFO_SYNC_ERR_EN
  logic         overflow, underflow;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_128 dut (
    .clk(clk), .reset(reset), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .o_rddata(rddata), .o_full(full), .o_empty(empty),
    .o_alm_full(alm_full), .o_alm_empty(alm_empty)
`ifdef FIFO_SYNC_ERR_EN
    , .o_overflow(overflow), .o_underflow(underflow)
`endif
  );

  typedef struct {
    logic         rst;
    logic         wr;
    logic         rd;
    logic [127:0] wd;
    logic [127:0] exp_rd;
    logic         exp_full;
    logic         exp_empty;
    logic         exp_af;
    logic         exp_ae;
    logic         exp_ovf;
    logic         exp_unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic wr, input logic rd,
                              input logic [127:0] wd, input logic [127:0] exp_rd,
                              input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.wd = wd; v.exp_rd = exp_rd;
    v.exp_full  = (cnt == 16);
    v.exp_empty = (cnt == 0);
    v.exp_af    = (cnt >= 12);
    v.exp_ae    = (cnt <= 4);
    v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    reset = v.rst; wren = v.wr; rden = v.rd; wrdata = v.wd;
    @(posedge clk);
    #1;
    chk("rddata", idx, rddata, v.exp_rd);
    chk("full", idx, 128'(full), 128'(v.exp_full));
    chk("empty", idx, 128'(empty), 128'(v.exp_empty));
    chk("alm_full", idx, 128'(alm_full), 128'(v.exp_af));
    chk("alm_empty", idx, 128'(alm_empty), 128'(v.exp_ae));
`ifdef FIFO_SYNC_ERR_EN
    chk("overflow", idx, 128'(overflow), 128'(v.exp_ovf));
    chk("underflow", idx, 128'(underflow), 128'(v.exp_unf));
`endif
    $display("vec%0d rst=%0b wr=%0b rd=%0b wd=%h rd_data=%h f=%0b e=%0b af=%0b ae=%0b",
             idx, v.rst, v.wr, v.rd, v.wd, rddata, full, empty, alm_full, alm_empty);
  endtask

  initial begin
    int idx;
    // Reset held two cycles with both requests active.
    tbl.push_back(mk(1, 1, 1, 128'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 128'hFF, 0, 0, 0, 0));
    // Fill 0x1..0x10.
    for (int i = 1; i <= 16; i++) tbl.push_back(mk(0, 1, 0, 128'(i), 0, i, 0, 0));
    // Write at full is dropped.
    tbl.push_back(mk(0, 1, 0, 128'hDEAD, 0, 16, 1, 0));
    // Drain in order.
    for (int i = 1; i <= 16; i++) tbl.push_back(mk(0, 0, 1, 0, 128'(i), 16 - i, 0, 0));
    // Read at empty: data held, count stays 0.
    tbl.push_back(mk(0, 0, 1, 0, 128'h10, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 128'h10, 0, 0, 0));
    // Refill 0x101..0x110, then read+write at full.
    for (int i = 1; i <= 16; i++) tbl.push_back(mk(0, 1, 0, 128'h100 + 128'(i), 128'h10, i, 0, 0));
    tbl.push_back(mk(0, 1, 1, 128'hBEEF, 128'h101, 15, 1, 0));
    for (int i = 2; i <= 16; i++) tbl.push_back(mk(0, 0, 1, 0, 128'h100 + 128'(i), 16 - i, 0, 0));
    // Read+write at empty: only the write lands.
    tbl.push_back(mk(0, 1, 1, 128'hA5, 128'h110, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 128'hA5, 0, 0, 0));
    // Streaming at count 8 for 40 cycles.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, 0, 128'h200 + 128'(i), 128'hA5, i + 1, 0, 0));
    for (int j = 0; j < 40; j++)
      tbl.push_back(mk(0, 1, 1, 128'h208 + 128'(j), 128'h200 + 128'(j), 8, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 1, 0, 128'h228 + 128'(i), 7 - i, 0, 0));

    idx = 0;
    foreach (tbl[k]) begin
      step(tbl[k], idx);
      idx++;
    end

    // Reset mid-burst discards stored data; next cycle works normally.
    step(mk(0, 1, 0, 128'h31, 128'h22F, 1, 0, 0), idx++);
    step(mk(0, 1, 0, 128'h32, 128'h22F, 2, 0, 0), idx++);
    step(mk(0, 1, 0, 128'h33, 128'h22F, 3, 0, 0), idx++);
    step(mk(1, 1, 0, 128'h34, 0, 0, 0, 0), idx++);
    step(mk(0, 1, 0, 128'h77, 0, 1, 0, 0), idx++);
    step(mk(0, 0, 1, 0, 128'h77, 0, 0, 0), idx++);
    step(mk(0, 0, 0, 0, 128'h77, 0, 0, 0), idx++);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
